ghost_move_sel: RTL

Reads the ghost distance map and picks one ghost's next grid step. The map is the 40x30 grid of 8-bit cells written by the ghost map writer: 255 is a wall, 254 is a current ghost, 253 is a previous ghost position, and any other value is the Manhattan distance to pacman. For each request the block reads the four orthogonal neighbours of the given ghost position through the map's read port and returns the reachable neighbour closest to pacman. It sits between the ghost map's read port and the ghost position registers in the game-tick logic.

---
 rtl/ghost_move_sel.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ghost_move_sel.sv
// Picks a ghost's next grid step: reads the four orthogonal map neighbours
// and returns the reachable one with the smallest distance to pacman.
module ghost_move_sel #(
  parameter int RD_LAT = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       map_ready,
  input  logic       start,
  input  logic [5:0] ghost_x,
  input  logic [4:0] ghost_y,
  input  logic [7:0] data,
  output logic [5:0] rdaddr_x,
  output logic [4:0] rdaddr_y,
  output logic [5:0] next_x,
  output logic [4:0] next_y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE} state_t;

  localparam logic [1:0] WAIT_LAST = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;
  localparam logic [7:0] SEED_VAL  = 8'd253;

  state_t     r_state, w_next;
  logic [5:0] r_gx, r_bx, r_rdx, r_nx;
  logic [4:0] r_gy, r_by, r_rdy, r_ny;
  logic [7:0] r_best;
  logic [1:0] r_dir, r_wcnt;
  logic       r_busy, r_done;

  logic [6:0] w_cx, w_cy;
  logic       w_oob, w_accept;

  assign w_accept = start && map_ready;

  // Candidate for the current direction, widened so that 0-1 lands far out of range.
  always_comb begin
    w_cx = {1'b0, r_gx};
    w_cy = {2'b0, r_gy};
    case (r_dir)
      2'd0:    w_cy = {2'b0, r_gy} - 7'd1;
      2'd1:    w_cx = {1'b0, r_gx} - 7'd1;
      2'd2:    w_cy = {2'b0, r_gy} + 7'd1;
      default: w_cx = {1'b0, r_gx} + 7'd1;
    endcase
    w_oob = (w_cx > 7'd39) || (w_cy > 7'd29);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = (RD_LAT == 1) ? S_EVAL : S_WAIT;
      S_WAIT:  if (r_wcnt == WAIT_LAST) w_next = S_EVAL;
      S_EVAL:  w_next = (r_dir == 2'd3) ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_gx   <= '0;
      r_gy   <= '0;
      r_bx   <= '0;
      r_by   <= '0;
      r_rdx  <= '0;
      r_rdy  <= '0;
      r_nx   <= '0;
      r_ny   <= '0;
      r_best <= '0;
      r_dir  <= '0;
      r_wcnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Cleared before the case so a back-to-back accept can set it again.
      if (r_done) r_busy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_gx   <= ghost_x;
            r_gy   <= ghost_y;
            r_bx   <= ghost_x;
            r_by   <= ghost_y;
            r_best <= SEED_VAL;
            r_dir  <= 2'd0;
            r_busy <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_wcnt <= '0;
          if (!w_oob) begin
            r_rdx <= w_cx[5:0];
            r_rdy <= w_cy[4:0];
          end
        end
        S_WAIT: r_wcnt <= r_wcnt + 2'd1;
        S_EVAL: begin
          // Seed of 253 rejects walls, ghosts and reversal; strict < keeps the earlier tie.
          if (!w_oob && (data < r_best)) begin
            r_best <= data;
            r_bx   <= w_cx[5:0];
            r_by   <= w_cy[4:0];
          end
          r_dir <= r_dir + 2'd1;
        end
        S_DONE: begin
          r_nx   <= r_bx;
          r_ny   <= r_by;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rdaddr_x = r_rdx;
  assign rdaddr_y = r_rdy;
  assign next_x   = r_nx;
  assign next_y   = r_ny;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
